// File: rtl/mem_port_pkg.sv
// Shared types and constants for the memory port controllers.
package mem_port_pkg;

  // Controller sequencing states.
  typedef enum logic [1:0] {
    IDLE,
    WR_ACK,
    RD_RUN,
    RD_LAST
  } mem_ctrl_state_t;

  // Each read beat carries this many consecutive words.
  localparam int MEM_PORT_WORDS_PER_BEAT = 2;

endpackage

// File: rtl/mem_port_if.sv
// Memory port bundle shared between clients and controllers.
interface mem_port_if #(
  parameter int PORT_ADDR_WIDTH   = 12,
  parameter int DATA_WIDTH        = 16,
  parameter int DQM_WIDTH         = 2,
  parameter int PORT_OUTPUT_WIDTH = DATA_WIDTH * 2
);

  logic [PORT_ADDR_WIDTH-1:0]   addr;
  logic [DATA_WIDTH-1:0]        data;
  logic [DQM_WIDTH-1:0]         byte_en;
  logic                         wr;
  logic                         rd;
  logic                         burst;
  logic [PORT_OUTPUT_WIDTH-1:0] q;
  logic                         available;
  logic                         ready;

  modport controller (
    input  addr, data, byte_en, wr, rd, burst,
    output q, available, ready
  );

  modport client (
    output addr, data, byte_en, wr, rd, burst,
    input  q, available, ready
  );

endinterface

// File: rtl/mem_port_bram_store.sv
// Word RAM with one byte-masked write port and two registered read ports.
// The array is replicated so each read port maps onto its own block RAM.
module mem_port_bram_store #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 16,
  parameter int DQM_WIDTH  = 2
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [DQM_WIDTH-1:0]  wbe,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr_a,
  input  logic [ADDR_WIDTH-1:0] raddr_b,
  output logic [DATA_WIDTH-1:0] rdata_a,
  output logic [DATA_WIDTH-1:0] rdata_b
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] bank_a [DEPTH];
  logic [DATA_WIDTH-1:0] bank_b [DEPTH];

  // Byte-lane write, applied identically to both banks.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < DQM_WIDTH; i++) begin
        if (wbe[i]) begin
          bank_a[waddr][8*i +: 8] <= wdata[8*i +: 8];
          bank_b[waddr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  // Registered reads; outputs hold while re is low.
  always_ff @(posedge clk) begin
    if (re) begin
      rdata_a <= bank_a[raddr_a];
      rdata_b <= bank_b[raddr_b];
    end
  end

endmodule

// File: rtl/mem_port_bram_ctrl.sv
// Block-RAM backed responder for the memory port controller modport.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | available; samples wr/rd
// WR_ACK  | write done at entry edge; ready pulse is visible this cycle
// RD_RUN  | one beat captured into q per cycle, next pair read issued
// RD_LAST | final beat is visible; back to IDLE next edge
module mem_port_bram_ctrl
  import mem_port_pkg::*;
#(
  parameter int PORT_ADDR_WIDTH   = 12,
  parameter int DATA_WIDTH        = 16,
  parameter int DQM_WIDTH         = 2,
  parameter int PORT_OUTPUT_WIDTH = DATA_WIDTH * 2,
  parameter int BURST_LEN         = 4
) (
  input  logic           clk,
  input  logic           reset,
  mem_port_if.controller port
);

  localparam int CNT_W = $clog2(BURST_LEN + 1);
  localparam logic [PORT_ADDR_WIDTH-1:0] BEAT_STRIDE = PORT_ADDR_WIDTH'(MEM_PORT_WORDS_PER_BEAT);
  localparam logic [PORT_ADDR_WIDTH-1:0] ADDR_ONE    = PORT_ADDR_WIDTH'(1);
  localparam logic [CNT_W-1:0]           BURST_BEATS = CNT_W'(BURST_LEN);
  localparam logic [CNT_W-1:0]           CNT_ONE     = CNT_W'(1);

  mem_ctrl_state_t state, state_next;

  logic                         available_q;
  logic                         ready_q;
  logic [PORT_OUTPUT_WIDTH-1:0] q_q;
  logic [PORT_ADDR_WIDTH-1:0]   addr_q, addr_next;
  logic [CNT_W-1:0]             beat_cnt, beat_cnt_next, beat_cnt_inc;
  logic [CNT_W-1:0]             beats_q, beats_next;
  logic                         ready_next;
  logic                         load_q;

  logic                         ram_we;
  logic                         ram_re;
  logic [PORT_ADDR_WIDTH-1:0]   rd_addr_lo;
  logic [PORT_ADDR_WIDTH-1:0]   rd_addr_hi;
  logic [DATA_WIDTH-1:0]        rdata_lo;
  logic [DATA_WIDTH-1:0]        rdata_hi;

  logic accept_wr;
  logic accept_rd;

  // Requests are only honoured while available; wr has priority over rd.
  assign accept_wr = available_q & port.wr;
  assign accept_rd = available_q & port.rd & ~port.wr;

  assign beat_cnt_inc = beat_cnt + CNT_ONE;
  assign rd_addr_hi   = rd_addr_lo + ADDR_ONE;

  // Next-state, datapath enables and read address selection.
  always_comb begin
    state_next    = state;
    addr_next     = addr_q;
    beat_cnt_next = beat_cnt;
    beats_next    = beats_q;
    ready_next    = 1'b0;
    load_q        = 1'b0;
    ram_we        = 1'b0;
    ram_re        = 1'b0;
    rd_addr_lo    = addr_q;
    case (state)
      IDLE: begin
        if (accept_wr) begin
          ram_we     = 1'b1;
          ready_next = 1'b1;
          state_next = WR_ACK;
        end else if (accept_rd) begin
          // First word pair is read straight from the request address so
          // beat 0 lands in q two cycles after acceptance.
          ram_re        = 1'b1;
          rd_addr_lo    = port.addr;
          addr_next     = port.addr + BEAT_STRIDE;
          beat_cnt_next = '0;
          beats_next    = port.burst ? BURST_BEATS : CNT_ONE;
          state_next    = RD_RUN;
        end
      end
      WR_ACK: begin
        state_next = IDLE;
      end
      RD_RUN: begin
        // Capture the pair read last edge and prefetch the next one; the
        // read issued alongside the final capture is simply never used.
        load_q        = 1'b1;
        ready_next    = 1'b1;
        ram_re        = 1'b1;
        addr_next     = addr_q + BEAT_STRIDE;
        beat_cnt_next = beat_cnt_inc;
        if (beat_cnt_inc == beats_q) begin
          state_next = RD_LAST;
        end
      end
      RD_LAST: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Output and burst-tracking registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      available_q <= 1'b0;
      ready_q     <= 1'b0;
      q_q         <= '0;
      addr_q      <= '0;
      beat_cnt    <= '0;
      beats_q     <= '0;
    end else begin
      available_q <= (state_next == IDLE);
      ready_q     <= ready_next;
      addr_q      <= addr_next;
      beat_cnt    <= beat_cnt_next;
      beats_q     <= beats_next;
      if (load_q) begin
        q_q <= PORT_OUTPUT_WIDTH'({rdata_hi, rdata_lo});
      end
    end
  end

  mem_port_bram_store #(
    .ADDR_WIDTH (PORT_ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .DQM_WIDTH  (DQM_WIDTH)
  ) u_store (
    .clk     (clk),
    .we      (ram_we),
    .waddr   (port.addr),
    .wdata   (port.data),
    .wbe     (port.byte_en),
    .re      (ram_re),
    .raddr_a (rd_addr_lo),
    .raddr_b (rd_addr_hi),
    .rdata_a (rdata_lo),
    .rdata_b (rdata_hi)
  );

  assign port.q         = q_q;
  assign port.available = available_q;
  assign port.ready     = ready_q;

endmodule

// File: doc/mem_port_bram_ctrl.md
Name: mem_port_bram_ctrl

Overview:
- Controller-side responder for the memory port interface: serves client read, burst-read and byte-masked write requests from on-chip block RAM.
- Used as the backing store for small memories, e.g. video/aux buffers, and as a cycle-accurate stand-in for the SDRAM controller in client benches.
- Implements the controller modport of mem_port_if exactly; clients need no changes when swapped against the SDRAM controller.

Parameters:
- PORT_ADDR_WIDTH, 12: word address width; depth D = 2**PORT_ADDR_WIDTH words.
- DATA_WIDTH, 16: word width.
- DQM_WIDTH, 2: byte-enable width; must equal DATA_WIDTH/8.
- PORT_OUTPUT_WIDTH, DATA_WIDTH*2: read beat width; fixed at two words.
- BURST_LEN, 4: beats returned when burst=1; range 1..16.

Ports:
- clk, input, 1: single clock; all logic on the rising edge.
- reset, input, 1: synchronous, active-high reset.
- port, mem_port_if.controller modport, with the following members:
  - addr, in, PORT_ADDR_WIDTH
  - data, in, DATA_WIDTH
  - byte_en, in, DQM_WIDTH
  - wr, in, 1
  - rd, in, 1
  - burst, in, 1
  - q, out, PORT_OUTPUT_WIDTH
  - available, out, 1
  - ready, out, 1

Behaviour:
- Reset values: available=0, ready=0, q=0, state=IDLE, beat counter=0. RAM contents are not reset. available rises the first cycle after reset deasserts.
- States:
  - IDLE: available=1.
  - WR_ACK
  - RD_RUN
  - RD_LAST
- Request sampling: rd/wr are sampled only when available=1. Requests while available=0 are ignored and are not queued.
- wr and rd both high: wr wins, rd is dropped.
- Write, accepted at cycle N:
  - mem[addr] byte lanes with byte_en[i]=1 take data[8i+7:8i]; other lanes are unchanged. The RAM write occurs at edge N.
  - State goes to WR_ACK; available=0 at N+1; ready=1 for exactly cycle N+1.
  - available=1 at N+2.
  - byte_en=0 still produces a ready pulse and leaves memory unchanged.
- Read, accepted at cycle N:
  - Latch addr as A and beats B = burst ? BURST_LEN : 1. available=0 from N+1.
  - Beat k (0..B-1) reads word address Ak = A+2k mod D.
  - q = {mem[Ak+1 mod D], mem[Ak]}, with the low word at A. A need not be even.
  - Beat k: ready=1 and q valid at cycle N+2+k. Beats are contiguous with no gaps.
  - available=1 at cycle N+2+B, one cycle after the final ready.
  - q holds its last value while ready=0.
- Address wrap: all address arithmetic is modulo D, so a read at D-1 returns {mem[0], mem[D-1]}.
- Read-during-write hazard: none, since the block is not available during a burst.
- Reset mid-operation: state returns to IDLE, ready drops immediately, remaining beats are discarded, and a write already clocked into RAM persists.
- Beat counter width is $clog2(BURST_LEN+1). Incrementing address registers are PORT_ADDR_WIDTH bits and wrap naturally.

Decomposition:
- Shared package mem_port_pkg holds:
  - typedef enum logic [1:0] mem_ctrl_state_t {IDLE, WR_ACK, RD_RUN, RD_LAST}
  - localparam MEM_PORT_WORDS_PER_BEAT = 2
- One sub-module, mem_port_bram_store:
  - Inferred RAM with one byte-masked write port and two registered read ports (replicated banks).
  - Two reads per cycle at addresses Ak and Ak+1.
  - Read latency one cycle.
- The top level holds the FSM, beat counter, address generation and output registers.

Test Plan:
- Reset release: hold reset 3 cycles then release -> available=0 during reset, 1 on the first cycle after, with ready=0 and q=0 throughout.
- Write then read: write addr 0x010 data 0xBEEF byte_en 2'b11, then 0x011 data 0x1234 -> ready pulse at N+1 each time and available back at N+2. Single read at 0x010 (burst=0) -> one ready at N+2 with q=0x1234BEEF, and available at N+3.
- Byte mask: after the above, write 0x010 data 0x55AA byte_en 2'b01 -> read 0x010 gives low word 0xBEAA; byte_en 2'b00 leaves it unchanged and still pulses ready.
- Burst with wrap: preload mem[k]=k for all k, then burst read at 0xFFD with BURST_LEN=4:
  - Expected beats 0x0FFE0FFD, 0x00000FFF, 0x00020001, 0x00040003 on cycles N+2..N+5.
  - available returns at N+6.
- Contention and ignore: assert rd and wr together -> only the write executes. Assert rd during a running burst -> no extra beats, and a memory check shows no side effects.
- Reset mid-burst: reset at N+3 of a 4-beat burst -> ready=0 from the next cycle, no further beats, then a clean single read succeeds after reset.
